// File: rtl/user_mgr_arb.sv
// Round-robin OBI manager arbiter with request locking and in-order response
// routing through an ID FIFO of granted port indices.
package user_mgr_arb_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } mgr_obi_a_t;

    typedef struct packed {
        logic       req;
        mgr_obi_a_t a;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [0:0]  rid;
    } mgr_obi_r_t;

    typedef struct packed {
        logic       gnt;
        logic       rvalid;
        mgr_obi_r_t r;
    } mgr_obi_rsp_t;
endpackage

module user_mgr_arb
    import user_mgr_arb_pkg::*;
#(
    parameter int unsigned NumMgr      = 2,
    parameter int unsigned NumMaxTrans = 2,
    parameter type         obi_req_t   = mgr_obi_req_t,
    parameter type         obi_rsp_t   = mgr_obi_rsp_t
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  obi_req_t [NumMgr-1:0] sbr_req_i,
    output obi_rsp_t [NumMgr-1:0] sbr_rsp_o,
    output obi_req_t              mgr_req_o,
    input  obi_rsp_t              mgr_rsp_i
);

    localparam int unsigned IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
    localparam int unsigned PtrW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
    localparam int unsigned CntW = $clog2(NumMaxTrans + 1);

    if (NumMgr < 2) begin : g_bad_num_mgr
        $error("user_mgr_arb: NumMgr must be at least 2");
    end
    if (NumMaxTrans < 1) begin : g_bad_max_trans
        $error("user_mgr_arb: NumMaxTrans must be at least 1");
    end

    logic [IdxW-1:0] fifo_q [NumMaxTrans];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            lock_q, lock_d;

    logic [IdxW-1:0] sel;
    logic [IdxW-1:0] cand;
    logic [IdxW-1:0] head;
    logic            any_req;
    logic            full;
    logic            empty;
    logic            req_out;
    logic            hs;
    logic            pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(NumMaxTrans - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [IdxW-1:0] idx_inc(input logic [IdxW-1:0] i);
        return (i == IdxW'(NumMgr - 1)) ? '0 : i + 1'b1;
    endfunction

    // A locked index bypasses the round-robin search until its handshake.
    always_comb begin
        sel     = rr_q;
        cand    = rr_q;
        any_req = 1'b0;
        if (lock_q) begin
            sel     = lock_idx_q;
            any_req = sbr_req_i[lock_idx_q].req;
        end else begin
            for (int off = int'(NumMgr) - 1; off >= 0; off--) begin
                cand = IdxW'((int'(rr_q) + off) % int'(NumMgr));
                if (sbr_req_i[cand].req) begin
                    sel     = cand;
                    any_req = 1'b1;
                end
            end
        end
    end

    assign full    = (cnt_q == CntW'(NumMaxTrans));
    assign empty   = (cnt_q == '0);
    assign req_out = any_req && !full && rst_ni;
    assign hs      = req_out && mgr_rsp_i.gnt;
    assign pop     = mgr_rsp_i.rvalid && !empty;
    assign head    = fifo_q[rptr_q];

    always_comb begin
        mgr_req_o = '0;
        if (req_out) begin
            mgr_req_o.a   = sbr_req_i[sel].a;
            mgr_req_o.req = 1'b1;
        end
    end

    always_comb begin
        sbr_rsp_o = '0;
        sbr_rsp_o[sel].gnt = hs;
        if (pop) begin
            sbr_rsp_o[head].rvalid = 1'b1;
            sbr_rsp_o[head].r      = mgr_rsp_i.r;
        end
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (hs) begin
            wptr_d = ptr_inc(wptr_q);
            rr_d   = idx_inc(sel);
            lock_d = 1'b0;
        end else if (req_out) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        // Simultaneous push and pop leaves the outstanding count unchanged.
        case ({hs, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumMaxTrans); i++) begin
                fifo_q[i] <= '0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            if (hs) begin
                fifo_q[wptr_q] <= sel;
            end
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // A response with nothing outstanding cannot be routed and is dropped.
    rvalid_has_owner: assert property (
        @(posedge clk_i) disable iff (!rst_ni) mgr_rsp_i.rvalid |-> !empty);

    held_request_stable: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (req_out && !mgr_rsp_i.gnt) |=> (mgr_req_o.req && $stable(mgr_req_o.a)));

endmodule
